// File: rtl/demux32bit_reg_pkg.sv
// Shared definitions for the store-path word demultiplexer.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package cpu_pkg;

   // Datapath word width shared with the 2-to-1 word mux.
   localparam int WORD_W = 32;

   // Default width of the optional per-channel delivered-word counters.
   localparam int CNT_W_DEF = 16;

   // Destination encodings carried on sel.
   localparam logic CH_MEM = 1'b0;   // data memory
   localparam logic CH_IO  = 1'b1;   // IO / peripheral port

   // One-entry output slot occupancy.
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   // A slot can take a new word when it is empty or its word leaves this cycle.
   function automatic logic slot_can_take(input logic vld, input logic rdy);
      return (!vld) || rdy;
   endfunction

endpackage

// File: rtl/demux32bit_reg_slot.sv
// One-entry valid/ready register slice holding a single word for one channel.
// Latency: 1 cycle from push to out_valid/out_data.
// Backpressure: holds word and valid steady while out_ready=0; caller gates push.
module demux_slot
   import cpu_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   slot_state_e      state;
   slot_state_e      state_nxt;
   logic [WIDTH-1:0] data_q;
   logic             pop;

   assign out_valid = (state == SLOT_FULL);
   assign pop       = out_valid & out_ready;
   assign out_data  = data_q;

   // Occupancy register; reset empties the slot and discards any held word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= SLOT_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Occupancy next state: fill on push, drain on pop, stay full on pop+push.
   always_comb begin
      state_nxt = state;
      case (state)
         SLOT_EMPTY: begin
            if (push) begin
               state_nxt = SLOT_FULL;
            end
         end
         SLOT_FULL: begin
            if (pop && !push) begin
               state_nxt = SLOT_EMPTY;
            end
         end
         default: begin
            state_nxt = SLOT_EMPTY;
         end
      endcase
   end

   // Word register; loads only on push so the last word stays visible after pop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q <= '0;
      end else if (push) begin
         data_q <= push_data;
      end
   end

endmodule

// File: rtl/demux32bit_reg.sv
// Registered 1-to-2 word demux: sel=0 to memory slot, sel=1 to IO slot; DEMUX_CNT_EN adds cnt0/cnt1.
// Latency: 1 cycle from accepted input to outN_valid; 1 word/cycle per channel.
// Backpressure: in_ready follows only the selected slot (empty or popping); low in reset.
module demux32bit_reg
   import cpu_pkg::*;
#(
   parameter int WIDTH = WORD_W
`ifdef DEMUX_CNT_EN
   ,
   parameter int CNT_W = CNT_W_DEF
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             sel,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_CNT_EN
   ,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
`endif
);

   logic ch0_take;
   logic ch1_take;
   logic accept;
   logic push0;
   logic push1;

   // Each slot's willingness depends only on its own state and consumer ready,
   // so the unselected channel never stalls the input.
   assign ch0_take = slot_can_take(out0_valid, out0_ready);
   assign ch1_take = slot_can_take(out1_valid, out1_ready);

   assign in_ready = rst_n & ((sel == CH_IO) ? ch1_take : ch0_take);
   assign accept   = in_valid & in_ready;

   // Select decode: exactly one slot sees the push of an accepted word.
   assign push0 = accept & (sel == CH_MEM);
   assign push1 = accept & (sel == CH_IO);

   demux_slot #(
      .WIDTH (WIDTH)
   ) u_slot_mem (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push0),
      .push_data (in_data),
      .out_ready (out0_ready),
      .out_valid (out0_valid),
      .out_data  (out0_data)
   );

   demux_slot #(
      .WIDTH (WIDTH)
   ) u_slot_io (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push1),
      .push_data (in_data),
      .out_ready (out1_ready),
      .out_valid (out1_valid),
      .out_data  (out1_data)
   );

`ifdef DEMUX_CNT_EN
   logic pop0;
   logic pop1;

   assign pop0 = out0_valid & out0_ready;
   assign pop1 = out1_valid & out1_ready;

   // Delivered-word counters; they wrap naturally modulo 2^CNT_W.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (pop0) begin
            cnt0 <= cnt0 + CNT_W'(1);
         end
         if (pop1) begin
            cnt1 <= cnt1 + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_demux32bit_reg.sv
// Self-checking bench: directed cases plus randomized traffic against a queue model.
// Latency: model expects words on the slot outputs one edge after acceptance.
// Backpressure: stimulus holds a stalled word; a monitor flags any change while stalled.
module tb_demux32bit_reg;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         sel;
   logic         out0_valid;
   logic         out0_ready;
   logic [W-1:0] out0_data;
   logic         out1_valid;
   logic         out1_ready;
   logic [W-1:0] out1_data;
`ifdef DEMUX_CNT_EN
   logic [15:0]  cnt0;
   logic [15:0]  cnt1;
   int           mc0 = 0;
   int           mc1 = 0;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: each channel is a queue of words still owed to its consumer,
   // plus the most recent word written to that channel (0 after reset).
   logic [W-1:0] q0[$];
   logic [W-1:0] q1[$];
   logic [W-1:0] last0 = '0;
   logic [W-1:0] last1 = '0;

   bit           prev_stall = 1'b0;
   logic         psel;
   logic [W-1:0] pdata;
   bit           acc;

   always #5 clk = ~clk;

   demux32bit_reg dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .sel        (sel),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out0_data  (out0_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out1_data  (out1_data)
`ifdef DEMUX_CNT_EN
      ,
      .cnt0       (cnt0),
      .cnt1       (cnt1)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: check in_ready against the model, let the edge happen, update
   // the model from the channel rules, then check every output.
   task automatic cycle(output bit accepted);
      bit           exp_rdy;
      bit           p0;
      bit           p1;
      bit           r;
      logic         s;
      logic [W-1:0] d;
      logic [W-1:0] dummy;
      #1;
      r = rst_n;
      s = sel;
      d = in_data;
      if (!r)     exp_rdy = 1'b0;
      else if (s) exp_rdy = (q1.size() == 0) || out1_ready;
      else        exp_rdy = (q0.size() == 0) || out0_ready;
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
      accepted = r && in_valid && exp_rdy;
      p0 = r && (q0.size() != 0) && out0_ready;
      p1 = r && (q1.size() != 0) && out1_ready;
      if (p0) chk("ch0_word", {32'd0, out0_data}, {32'd0, q0[0]});
      if (p1) chk("ch1_word", {32'd0, out1_data}, {32'd0, q1[0]});
      @(posedge clk);
      if (!r) begin
         q0.delete();
         q1.delete();
         last0 = '0;
         last1 = '0;
`ifdef DEMUX_CNT_EN
         mc0 = 0;
         mc1 = 0;
`endif
      end else begin
         if (p0) begin
            dummy = q0.pop_front();
`ifdef DEMUX_CNT_EN
            mc0 = (mc0 + 1) % 65536;
`endif
         end
         if (p1) begin
            dummy = q1.pop_front();
`ifdef DEMUX_CNT_EN
            mc1 = (mc1 + 1) % 65536;
`endif
         end
         if (accepted) begin
            if (s) begin
               q1.push_back(d);
               last1 = d;
            end else begin
               q0.push_back(d);
               last0 = d;
            end
         end
      end
      #1;
      chk("out0_valid", {63'd0, out0_valid}, {63'd0, (q0.size() != 0)});
      chk("out0_data",  {32'd0, out0_data},  {32'd0, last0});
      chk("out1_valid", {63'd0, out1_valid}, {63'd0, (q1.size() != 0)});
      chk("out1_data",  {32'd0, out1_data},  {32'd0, last1});
`ifdef DEMUX_CNT_EN
      chk("cnt0", {48'd0, cnt0}, 64'(mc0));
      chk("cnt1", {48'd0, cnt1}, 64'(mc1));
`endif
   endtask

   task automatic drive(input bit r, input bit v, input bit s, input logic [W-1:0] d,
                        input bit rd0, input bit rd1);
      rst_n      = r;
      in_valid   = v;
      sel        = s;
      in_data    = d;
      out0_ready = rd0;
      out1_ready = rd1;
   endtask

   // Protocol monitor: a stalled word must keep its sel and data.
   always @(negedge clk) begin
      if (prev_stall && in_valid) begin
         chk("proto_hold", {31'd0, sel, in_data}, {31'd0, psel, pdata});
      end
      prev_stall = rst_n && in_valid && !in_ready;
      psel       = sel;
      pdata      = in_data;
   end

   initial begin
      // Reset held 3 cycles with a word offered.
      drive(1'b0, 1'b1, 1'b0, 32'h1111_1111, 1'b1, 1'b1);
      repeat (3) cycle(acc);
      chk("rst_out0_valid", {63'd0, out0_valid}, 64'd0);
      chk("rst_out1_data", {32'd0, out1_data}, 64'd0);

      // Single route to channel 1, then to channel 0.
      drive(1'b1, 1'b1, 1'b1, 32'h0000_000E, 1'b1, 1'b1);
      cycle(acc);
      chk("route1_data", {32'd0, out1_data}, 64'h0000_000E);
      chk("route1_ch0_idle", {63'd0, out0_valid}, 64'd0);
      drive(1'b1, 1'b1, 1'b0, 32'h0000_00F0, 1'b1, 1'b1);
      cycle(acc);
      chk("route0_data", {32'd0, out0_data}, 64'h0000_00F0);
      drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1);
      cycle(acc);

      // Back-pressure on channel 0 must not block channel 1.
      drive(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1);
      cycle(acc);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      cycle(acc);
      chk("bp_in_ready_ch0", {63'd0, in_ready}, 64'd0);
      drive(1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b1);
      cycle(acc);
      chk("bp_ch1_accepted", {63'd0, acc}, 64'd1);
      chk("bp_ch0_held", {32'd0, out0_data}, 64'hDEAD_BEEF);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      repeat (2) cycle(acc);
      chk("bp_ch0_delivered_once", {63'd0, out0_valid}, 64'd0);

      // Streaming: 8 words alternating channels at full rate.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1, i[0], 32'(i + 1) * 32'h0101_0101, 1'b1, 1'b1);
         cycle(acc);
         chk("stream_accept", {63'd0, acc}, 64'd1);
      end
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      cycle(acc);

      // Simultaneous pop and push on a full channel 0.
      drive(1'b1, 1'b1, 1'b0, 32'hA5A5_A5A5, 1'b0, 1'b1);
      cycle(acc);
      drive(1'b1, 1'b1, 1'b0, 32'h5A5A_5A5A, 1'b1, 1'b1);
      cycle(acc);
      chk("poppush_valid", {63'd0, out0_valid}, 64'd1);
      chk("popush_data", {32'd0, out0_data}, 64'h5A5A_5A5A);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      cycle(acc);

      // Reset while a word is buffered drops it.
      drive(1'b1, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0);
      cycle(acc);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      cycle(acc);
      chk("midrst_drop", {63'd0, out0_valid}, 64'd0);
      chk("midrst_data", {32'd0, out0_data}, 64'd0);

`ifdef DEMUX_CNT_EN
      // 5 channel-0 pops and 3 channel-1 pops.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1, (i == 1 || i == 3 || i == 5), $urandom, 1'b1, 1'b1);
         cycle(acc);
      end
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      cycle(acc);
      chk("cnt0_five", {48'd0, cnt0}, 64'd5);
      chk("cnt1_three", {48'd0, cnt1}, 64'd3);

      // Counter wrap: 65535 pops then one more.
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      cycle(acc);
      for (int i = 0; i < 65535; i++) begin
         drive(1'b1, 1'b1, 1'b0, $urandom, 1'b1, 1'b1);
         cycle(acc);
      end
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      cycle(acc);
      chk("cnt0_max", {48'd0, cnt0}, 64'h0000_FFFF);
      drive(1'b1, 1'b1, 1'b0, $urandom, 1'b1, 1'b1);
      cycle(acc);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      cycle(acc);
      chk("cnt0_wrap", {48'd0, cnt0}, 64'd0);

      // Reset mid-stream clears the counters.
      drive(1'b1, 1'b1, 1'b1, $urandom, 1'b1, 1'b0);
      cycle(acc);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      cycle(acc);
      chk("cnt_rst0", {48'd0, cnt0}, 64'd0);
      chk("cnt_rst1", {48'd0, cnt1}, 64'd0);
`endif

      // Randomized traffic with occasional resets; stalled words are held.
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      acc = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!(in_valid && !acc)) begin
            in_valid = ($urandom_range(3) != 0);
            sel      = 1'($urandom_range(1));
            in_data  = $urandom;
         end
         out0_ready = ($urandom_range(9) < 7);
         out1_ready = ($urandom_range(9) < 6);
         rst_n      = ($urandom_range(199) != 0);
         cycle(acc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
